ps2_key_encoder: RTL and testbench

- Produces the ps2_key[10:0] toggle-event word that the core's keyboard decoder consumes.
- Input is a raw PS/2 Set-2 scancode byte stream: bytes from a PS/2 deserializer on USER_IN, or test bytes.
- Parses the E0 (extended), F0 (break) and E1 (pause) prefixes and buffers decoded events in a small FIFO.
- Emits each event as a toggle of bit 10, with guaranteed spacing, so a same-clock consumer that compares old and new bit 10 never misses an event.

---
 rtl/ps2_key_encoder.sv | 179 +++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 Set-2 scancode byte stream -> ps2_key[10:0] toggle-event word.
// Parses E0/F0/E1 prefixes, buffers events in a small FIFO and releases them
// with at least MIN_GAP cycles between ps2_key updates.
// Optional build macro PS2_TYPEMATIC_FILTER_EN drops typematic repeat makes.
module ps2_key_encoder #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned MIN_GAP = 4
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [10:0]        ps2_key,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned GW    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         pause_cnt, pause_nxt;
  logic               accept_c;
  logic               is_resp_c;
  logic               is_fake_c;
  logic               push_raw_c;
  logic               push_c;
  logic               pop_c;
  logic [9:0]         push_data_c;
  logic [9:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count_nxt;
  logic [GW-1:0]      gap_cnt;

  assign accept_c  = byte_valid && byte_ready;
  assign is_resp_c = byte_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  assign is_fake_c = (byte_in == 8'h12) || (byte_in == 8'h59);

  // Parser state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pause_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      pause_cnt <= pause_nxt;
    end
  end

  // Parser next state and event generation; only moves on an accepted byte.
  always_comb begin
    state_nxt   = state;
    pause_nxt   = pause_cnt;
    push_raw_c  = 1'b0;
    push_data_c = {1'b1, 1'b0, byte_in};
    if (accept_c) begin
      case (state)
        S_IDLE: begin
          if (byte_in == 8'hE0) begin
            state_nxt = S_EXT;
          end else if (byte_in == 8'hF0) begin
            state_nxt = S_BRK;
          end else if (byte_in == 8'hE1) begin
            state_nxt = S_PAUSE;
            pause_nxt = 3'd7;
          end else if (!is_resp_c) begin
            push_raw_c = 1'b1;
          end
        end
        S_EXT: begin
          if (byte_in == 8'hF0) begin
            state_nxt = S_EXT_BRK;
          end else if (byte_in != 8'hE0) begin
            state_nxt = S_IDLE;
            if (!is_fake_c) begin
              push_raw_c  = 1'b1;
              push_data_c = {1'b1, 1'b1, byte_in};
            end
          end
        end
        S_BRK: begin
          state_nxt   = S_IDLE;
          push_raw_c  = 1'b1;
          push_data_c = {1'b0, 1'b0, byte_in};
        end
        S_EXT_BRK: begin
          state_nxt = S_IDLE;
          if (!is_fake_c) begin
            push_raw_c  = 1'b1;
            push_data_c = {1'b0, 1'b1, byte_in};
          end
        end
        S_PAUSE: begin
          pause_nxt = pause_cnt - 3'd1;
          if (pause_cnt == 3'd1) begin
            state_nxt   = S_IDLE;
            push_raw_c  = 1'b1;
            push_data_c = {1'b1, 1'b1, 8'h77};
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       filt_vld;
  logic [8:0] filt_code;
  logic       filt_hit_c;

  assign filt_hit_c = filt_vld && (filt_code == push_data_c[8:0]);
  assign push_c     = push_raw_c && !(push_data_c[9] && filt_hit_c);

  // Remember the last make; a matching break re-arms it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      filt_vld  <= 1'b0;
      filt_code <= 9'd0;
    end else if (push_raw_c) begin
      if (push_data_c[9]) begin
        if (!filt_hit_c) begin
          filt_vld  <= 1'b1;
          filt_code <= push_data_c[8:0];
        end
      end else if (filt_hit_c) begin
        filt_vld <= 1'b0;
      end
    end
  end
`else
  assign push_c = push_raw_c;
`endif

  assign pop_c     = (fifo_count != '0) && (gap_cnt == '0);
  assign count_nxt = fifo_count + CW'(push_c) - CW'(pop_c);

  // FIFO pointers, occupancy and registered ready (from next occupancy so a full FIFO never accepts).
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      byte_ready <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + 1'b1;
      if (pop_c)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_nxt;
      byte_ready <= count_nxt < CW'(DEPTH);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_sys) begin
    if (push_c) fifo_mem[wr_ptr] <= push_data_c;
  end

  // Output stage: pop head, flip the toggle bit, then hold off for MIN_GAP cycles.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_key <= 11'd0;
      gap_cnt <= '0;
    end else if (pop_c) begin
      ps2_key <= {~ps2_key[10], fifo_mem[rd_ptr]};
      gap_cnt <= GW'(MIN_GAP - 1);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: two instances (MIN_GAP 4 and 200) driven from
// directed and random byte streams, checked against a scancode-level model.
module tb_ps2_key_encoder;

  localparam int GAP_A = 4;
  localparam int GAP_B = 200;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic        ready_a, ready_b;
  logic [10:0] key_a, key_b;
  logic [2:0]  cnt_a, cnt_b;

  always #5 clk_sys = ~clk_sys;

  ps2_key_encoder #(.FIFO_AW(2), .MIN_GAP(GAP_A)) u_dut_a (
    .clk_sys(clk_sys), .reset(reset), .byte_in(byte_in), .byte_valid(valid_a),
    .byte_ready(ready_a), .ps2_key(key_a), .fifo_count(cnt_a));

  ps2_key_encoder #(.FIFO_AW(2), .MIN_GAP(GAP_B)) u_dut_b (
    .clk_sys(clk_sys), .reset(reset), .byte_in(byte_in), .byte_valid(valid_b),
    .byte_ready(ready_b), .ps2_key(key_b), .fifo_count(cnt_b));

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  always @(posedge clk_sys) edge_cnt <= edge_cnt + 1;

  // Observed events: every change of bit 10, stamped with the edge that produced it.
  logic [10:0] obs_key_a[$], obs_key_b[$];
  int          obs_edge_a[$], obs_edge_b[$];
  int          obs_tot_a = 0, obs_tot_b = 0;
  logic        last_a = 1'b0, last_b = 1'b0;

  // Event collector.
  always @(negedge clk_sys) begin
    if (reset) begin
      last_a <= 1'b0;
      last_b <= 1'b0;
    end else begin
      if (key_a[10] !== last_a) begin
        obs_key_a.push_back(key_a);
        obs_edge_a.push_back(edge_cnt);
        obs_tot_a <= obs_tot_a + 1;
        last_a    <= key_a[10];
      end
      if (key_b[10] !== last_b) begin
        obs_key_b.push_back(key_b);
        obs_edge_b.push_back(edge_cnt);
        obs_tot_b <= obs_tot_b + 1;
        last_b    <= key_b[10];
      end
    end
  end

  // Reference model: prefix flags per instance, expected event words.
  logic        m_ext[2], m_brk[2];
  int          m_pause[2], m_events[2];
  logic        m_fv[2];
  logic [8:0]  m_fr[2];
  logic [10:0] exp_a[$], exp_b[$];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_ext[s] = 1'b0; m_brk[s] = 1'b0; m_pause[s] = 0; m_events[s] = 0;
      m_fv[s] = 1'b0; m_fr[s] = 9'd0;
    end
    exp_a.delete(); exp_b.delete();
    obs_key_a.delete(); obs_key_b.delete();
    obs_edge_a.delete(); obs_edge_b.delete();
    obs_tot_a = 0; obs_tot_b = 0;
  endtask

  task automatic model_push(input int s, input logic [9:0] ev);
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (ev[9]) begin
      if (m_fv[s] && m_fr[s] == ev[8:0]) return;
      m_fr[s] = ev[8:0];
      m_fv[s] = 1'b1;
    end else if (m_fv[s] && m_fr[s] == ev[8:0]) begin
      m_fv[s] = 1'b0;
    end
`endif
    m_events[s]++;
    if (s == 0) exp_a.push_back({m_events[s][0], ev});
    else        exp_b.push_back({m_events[s][0], ev});
  endtask

  task automatic model_byte(input int s, input logic [7:0] b);
    bit fake;
    fake = (b == 8'h12) || (b == 8'h59);
    if (m_pause[s] > 0) begin
      m_pause[s]--;
      if (m_pause[s] == 0) model_push(s, {2'b11, 8'h77});
    end else if (m_brk[s]) begin
      if (!(m_ext[s] && fake)) model_push(s, {1'b0, m_ext[s], b});
      m_brk[s] = 1'b0;
      m_ext[s] = 1'b0;
    end else if (m_ext[s]) begin
      if (b == 8'hF0) m_brk[s] = 1'b1;
      else if (b != 8'hE0) begin
        if (!fake) model_push(s, {2'b11, b});
        m_ext[s] = 1'b0;
      end
    end else begin
      case (b)
        8'hE0: m_ext[s] = 1'b1;
        8'hF0: m_brk[s] = 1'b1;
        8'hE1: m_pause[s] = 7;
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: ;
        default: model_push(s, {2'b10, b});
      endcase
    end
  endtask

  // Present one byte (called at a negedge); returns accepting edge or -1. Leaves valid high.
  task automatic send(input int s, input logic [7:0] b, output int acc);
    bit done;
    done    = 1'b0;
    acc     = -1;
    byte_in = b;
    if (s == 0) valid_a = 1'b1; else valid_b = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      if ((s == 0) ? ready_a : ready_b) begin
        acc  = edge_cnt + 1;
        done = 1'b1;
      end
      @(negedge clk_sys);
    end
    if (done) model_byte(s, b);
  endtask

  task automatic idle();
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // Wait until all modelled events were observed, then settle to catch extras.
  task automatic drain(input int s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((s == 0) ? (obs_key_a.size() >= exp_a.size()) : (obs_key_b.size() >= exp_b.size())) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    repeat ((s == 0) ? GAP_A + 8 : 20) @(negedge clk_sys);
    #1;
  endtask

  logic [7:0] seqs [17] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                            8'hE0, 8'h12, 8'hE0, 8'h7C,
                            8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  int         seq_len [3] = '{5, 4, 8};
  int         seq_evs [3] = '{2, 1, 1};
  logic [7:0] resp_b  [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  logic [7:0] pause_b [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] hot_b   [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
  logic [7:0] fill_b  [6] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

  task automatic test_reset();
    reset = 1'b1;
    idle();
    model_reset();
    repeat (3) @(negedge clk_sys);
    checks++; if (key_a !== 11'd0)  begin failures++; $display("FAIL reset_key_a got %h want 000", key_a); end
    checks++; if (cnt_a !== 3'd0)   begin failures++; $display("FAIL reset_count_a got %0d want 0", cnt_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready_a got %b want 0", ready_a); end
    checks++; if (key_b !== 11'd0)  begin failures++; $display("FAIL reset_key_b got %h want 000", key_b); end
    checks++; if (ready_b !== 1'b0) begin failures++; $display("FAIL reset_ready_b got %b want 0", ready_b); end
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL release_ready_a got %b want 1", ready_a); end
    checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL release_ready_b got %b want 1", ready_b); end
  endtask

  task automatic test_make_break();
    int acc1, acc; bit ok; int prev; logic [10:0] k, x; int e;
    send(0, 8'h1C, acc1);
    send(0, 8'hF0, acc);
    send(0, 8'h1C, acc);
    idle();
    drain(0, 200, ok);
    checks++; if (!ok || acc1 < 0 || acc < 0) begin failures++; $display("FAIL mb_timeout got ok=%b acc=%0d want ok=1", ok, acc); end
    checks++; if (obs_key_a.size() != exp_a.size()) begin failures++; $display("FAIL mb_count got %0d want %0d", obs_key_a.size(), exp_a.size()); end
    checks++; if (obs_edge_a.size() > 0 && obs_edge_a[0] != acc1 + 1) begin failures++; $display("FAIL mb_latency got edge %0d want %0d", obs_edge_a[0], acc1 + 1); end
    prev = -1;
    while (exp_a.size() > 0 && obs_key_a.size() > 0) begin
      k = obs_key_a.pop_front(); e = obs_edge_a.pop_front(); x = exp_a.pop_front();
      checks++; if (k !== x) begin failures++; $display("FAIL mb_key got %h want %h", k, x); end
      if (prev >= 0) begin
        checks++; if (e - prev < GAP_A) begin failures++; $display("FAIL mb_gap got %0d want >=%0d", e - prev, GAP_A); end
      end
      prev = e;
    end
    exp_a.delete(); obs_key_a.delete(); obs_edge_a.delete();
  endtask

  task automatic test_prefixes();
    int acc, base, acc_bad; bit ok; logic [10:0] k, x;
    base = 0;
    for (int q = 0; q < 3; q++) begin
      acc_bad = 0;
      for (int j = 0; j < seq_len[q]; j++) begin
        send(0, seqs[base + j], acc);
        if (acc < 0) acc_bad++;
      end
      base += seq_len[q];
      idle();
      drain(0, 300, ok);
      checks++; if (!ok || acc_bad != 0) begin failures++; $display("FAIL prefix%0d_timeout got ok=%b stalls=%0d want ok=1", q, ok, acc_bad); end
      checks++; if (obs_key_a.size() != seq_evs[q]) begin failures++; $display("FAIL prefix%0d_events got %0d want %0d", q, obs_key_a.size(), seq_evs[q]); end
      while (exp_a.size() > 0 && obs_key_a.size() > 0) begin
        k = obs_key_a.pop_front(); x = exp_a.pop_front();
        checks++; if (k !== x) begin failures++; $display("FAIL prefix%0d_key got %h want %h", q, k, x); end
      end
      exp_a.delete(); obs_key_a.delete(); obs_edge_a.delete();
    end
  endtask

  task automatic test_fifo_full();
    int acc [6]; bit ok; int prev; logic [10:0] k, x; int e;
    for (int i = 0; i < 5; i++) send(1, fill_b[i], acc[i]);
    #1;
    for (int i = 1; i < 5; i++) begin
      checks++; if (acc[i] != acc[0] + i) begin failures++; $display("FAIL full_b2b_accept%0d got %0d want %0d", i, acc[i], acc[0] + i); end
    end
    checks++; if (cnt_b !== 3'(m_events[1] - obs_tot_b)) begin failures++; $display("FAIL full_count got %0d want %0d", cnt_b, m_events[1] - obs_tot_b); end
    checks++; if (ready_b !== 1'b0) begin failures++; $display("FAIL full_ready got %b want 0", ready_b); end
    send(1, fill_b[5], acc[5]);
    idle();
    checks++; if (acc[5] < 0 || obs_edge_b.size() < 2 || acc[5] != obs_edge_b[1] + 1) begin
      failures++; $display("FAIL full_reaccept got edge %0d want one after second pop", acc[5]);
    end
    drain(1, 2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got %0d events want %0d", obs_key_b.size(), exp_b.size()); end
    checks++; if (obs_key_b.size() != 6) begin failures++; $display("FAIL full_events got %0d want 6", obs_key_b.size()); end
    prev = -1;
    while (exp_b.size() > 0 && obs_key_b.size() > 0) begin
      k = obs_key_b.pop_front(); e = obs_edge_b.pop_front(); x = exp_b.pop_front();
      checks++; if (k !== x) begin failures++; $display("FAIL full_key got %h want %h", k, x); end
      if (prev >= 0) begin
        checks++; if (e - prev != GAP_B) begin failures++; $display("FAIL full_spacing got %0d want %0d", e - prev, GAP_B); end
      end
      prev = e;
    end
    exp_b.delete(); obs_key_b.delete(); obs_edge_b.delete();
  endtask

  task automatic test_random();
    int acc, cat, stalls; bit ok; int prev; logic [10:0] k, x; int e;
    logic [7:0] bl[$];
    stalls = 0;
    for (int it = 0; it < 70; it++) begin
      bl.delete();
      cat = $urandom_range(0, 11);
      case (cat)
        0: bl.push_back(8'hE0);
        1: bl.push_back(8'hF0);
        2: bl.push_back(resp_b[$urandom_range(0, 7)]);
        3: bl.push_back(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59);
        4: for (int j = 0; j < 8; j++) bl.push_back(pause_b[j]);
        5, 6, 7: bl.push_back(hot_b[$urandom_range(0, 3)]);
        default: bl.push_back(8'($urandom_range(0, 255)));
      endcase
      foreach (bl[j]) begin
        send(0, bl[j], acc);
        if (acc < 0) stalls++;
        #1;
        checks++; if (cnt_a !== 3'(m_events[0] - obs_tot_a)) begin
          failures++; $display("FAIL rand_count got %0d want %0d", cnt_a, m_events[0] - obs_tot_a);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 6)) @(negedge clk_sys);
      end
    end
    idle();
    drain(0, 3000, ok);
    checks++; if (!ok || stalls != 0) begin failures++; $display("FAIL rand_timeout got ok=%b stalls=%0d want ok=1", ok, stalls); end
    checks++; if (obs_key_a.size() != exp_a.size()) begin failures++; $display("FAIL rand_events got %0d want %0d", obs_key_a.size(), exp_a.size()); end
    prev = -1;
    while (exp_a.size() > 0 && obs_key_a.size() > 0) begin
      k = obs_key_a.pop_front(); e = obs_edge_a.pop_front(); x = exp_a.pop_front();
      checks++; if (k !== x) begin failures++; $display("FAIL rand_key got %h want %h", k, x); end
      if (prev >= 0) begin
        checks++; if (e - prev < GAP_A) begin failures++; $display("FAIL rand_gap got %0d want >=%0d", e - prev, GAP_A); end
      end
      prev = e;
    end
    exp_a.delete(); obs_key_a.delete(); obs_edge_a.delete();
  endtask

  task automatic test_reset_mid();
    int acc, acc29, stalls; bit ok; logic [10:0] k, x;
    logic [7:0] pre [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hE0};
    logic [7:0] rep [5] = '{8'h29, 8'hF0, 8'h29, 8'h29, 8'h29};
    stalls = 0;
    foreach (pre[j]) begin
      send(0, pre[j], acc);
      if (acc < 0) stalls++;
    end
    #1;
    checks++; if (stalls != 0 || cnt_a !== 3'(m_events[0] - obs_tot_a)) begin
      failures++; $display("FAIL mid_queued got %0d want %0d", cnt_a, m_events[0] - obs_tot_a);
    end
    idle();
    #2 reset = 1'b1;
    #1;
    checks++; if (key_a !== 11'd0)  begin failures++; $display("FAIL mid_reset_key got %h want 000", key_a); end
    checks++; if (cnt_a !== 3'd0)   begin failures++; $display("FAIL mid_reset_count got %0d want 0", cnt_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got %b want 0", ready_a); end
    model_reset();
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    send(0, 8'h29, acc29);
    idle();
    drain(0, 200, ok);
    checks++; if (!ok || acc29 < 0) begin failures++; $display("FAIL mid_timeout got ok=%b want 1", ok); end
    checks++; if (obs_key_a.size() != 1 || obs_key_a[0] !== 11'h629) begin
      failures++; $display("FAIL mid_first_key got %h (n=%0d) want 629", (obs_key_a.size() > 0) ? obs_key_a[0] : 11'h0, obs_key_a.size());
    end
    checks++; if (obs_edge_a.size() > 0 && obs_edge_a[0] != acc29 + 1) begin failures++; $display("FAIL mid_latency got %0d want %0d", obs_edge_a[0], acc29 + 1); end
    exp_a.delete(); obs_key_a.delete(); obs_edge_a.delete();
    stalls = 0;
    foreach (rep[j]) begin
      send(0, rep[j], acc);
      if (acc < 0) stalls++;
    end
    idle();
    drain(0, 300, ok);
    checks++; if (!ok || stalls != 0) begin failures++; $display("FAIL rep_timeout got ok=%b stalls=%0d want ok=1", ok, stalls); end
    checks++; if (obs_key_a.size() != exp_a.size()) begin failures++; $display("FAIL rep_events got %0d want %0d", obs_key_a.size(), exp_a.size()); end
    while (exp_a.size() > 0 && obs_key_a.size() > 0) begin
      k = obs_key_a.pop_front(); x = exp_a.pop_front();
      checks++; if (k !== x) begin failures++; $display("FAIL rep_key got %h want %h", k, x); end
    end
    exp_a.delete(); obs_key_a.delete(); obs_edge_a.delete();
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_prefixes();
    test_fifo_full();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
